wb_arbiter_2x1: RTL and testbench

- Two-master to one-slave Wishbone arbiter: shares a single Wishbone slave port (e.g. the peripheral Wishbone interconnect behind the AXI4-to-WB bridge) between two Wishbone masters.
- Round-robin arbitration; a grant is held for a master's whole CYC window.
- Includes a per-transfer bus watchdog: it aborts a stalled transfer and returns ERR to the master, so a hung peripheral cannot lock out the other master.

---
 rtl/wb_arbiter_2x1.sv | 183 ++++++++++++++++++
 tb/tb_wb_arbiter_2x1.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2x1
//   Shares one Wishbone slave port between two Wishbone masters.
//   Round-robin arbitration; a grant is held for the owner's whole CYC window.
//   A per-transfer watchdog aborts a stalled strobe and returns ERR to the
//   owning master, so a hung slave cannot lock out the other master.
//
// Ports
//   clk, rstn              clock (posedge), asynchronous active-low reset
//   m0_* / m1_*            master-side Wishbone (adr, dat_w, sel, cyc, stb, we
//                          in; dat_r, ack, err out)
//   s_*                    slave-side Wishbone (adr, dat_w, sel, cyc, stb, we
//                          out; dat_r, ack, err in)
//   gnt                    one-hot current grant {m1,m0}; 00 = none
//   timeout                one-cycle pulse while a stalled transfer is aborted
// ---------------------------------------------------------------------------
module wb_arbiter_2x1 #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   m0_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m0_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0] m0_sel,
    input  logic                       m0_cyc,
    input  logic                       m0_stb,
    input  logic                       m0_we,
    output logic [WB_DATA_WIDTH-1:0]   m0_dat_r,
    output logic                       m0_ack,
    output logic                       m0_err,
    input  logic [WB_ADDR_WIDTH-1:0]   m1_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m1_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0] m1_sel,
    input  logic                       m1_cyc,
    input  logic                       m1_stb,
    input  logic                       m1_we,
    output logic [WB_DATA_WIDTH-1:0]   m1_dat_r,
    output logic                       m1_ack,
    output logic                       m1_err,
    output logic [WB_ADDR_WIDTH-1:0]   s_adr,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel,
    output logic                       s_cyc,
    output logic                       s_stb,
    output logic                       s_we,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
    input  logic                       s_ack,
    input  logic                       s_err,
    output logic [1:0]                 gnt,
    output logic                       timeout
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        WD_ENABLED = (TIMEOUT_CYCLES != 0);

    state_t      r_state, w_next_state;
    logic        r_last_grant, w_next_last_grant;
    logic [15:0] r_wd_cnt, w_next_wd_cnt;
    logic        w_stall;
    logic        w_wd_fire;

    // Read data is broadcast; only the granted master sees ack/err.
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    // Output mux, purely a function of the current state.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        gnt     = 2'b00;
        timeout = 1'b0;
        case (r_state)
            GNT0: begin
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                m0_ack  = s_ack;
                m0_err  = s_err;
                gnt     = 2'b01;
            end
            GNT1: begin
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                m1_ack  = s_ack;
                m1_err  = s_err;
                gnt     = 2'b10;
            end
            ABORT: begin
                // last_grant still names the master whose transfer was cut off.
                timeout = 1'b1;
                if (r_last_grant) m1_err = 1'b1;
                else              m0_err = 1'b1;
            end
            default: ;
        endcase
    end

    // A strobe is stalled while the slave gives neither ack nor err.
    assign w_stall   = (r_state == GNT0 || r_state == GNT1) && s_stb && !s_ack && !s_err;
    assign w_wd_fire = WD_ENABLED && w_stall && (r_wd_cnt == WD_LIMIT);

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (m0_cyc && (!m1_cyc || r_last_grant)) begin
                    w_next_state      = GNT0;
                    w_next_last_grant = 1'b0;
                end else if (m1_cyc) begin
                    w_next_state      = GNT1;
                    w_next_last_grant = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    if (m1_cyc) begin
                        w_next_state      = GNT1;
                        w_next_last_grant = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_wd_fire) begin
                    w_next_state = ABORT;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    if (m0_cyc) begin
                        w_next_state      = GNT0;
                        w_next_last_grant = 1'b0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_wd_fire) begin
                    w_next_state = ABORT;
                end
            end
            ABORT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Counter restarts on any response, idle strobe or state change.
    always_comb begin
        w_next_wd_cnt = '0;
        if (w_stall && (w_next_state == r_state))
            w_next_wd_cnt = r_wd_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_wd_cnt     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_wd_cnt     <= w_next_wd_cnt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_2x1
//   Directed bench for wb_arbiter_2x1. The main instance uses a 4-cycle
//   watchdog; a second instance sharing the same inputs has the watchdog off.
//   Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_2x1;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_dat_w, m1_dat_w;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [DW-1:0] s_dat_r;
    logic          s_ack, s_err;

    logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_w;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [AW-1:0] s_adr;
    logic [3:0]    s_sel;
    logic          s_cyc, s_stb, s_we, timeout;
    logic [1:0]    gnt;

    logic [DW-1:0] t0_m0_dat_r, t0_m1_dat_r, t0_s_dat_w;
    logic          t0_m0_ack, t0_m0_err, t0_m1_ack, t0_m1_err;
    logic [AW-1:0] t0_s_adr;
    logic [3:0]    t0_s_sel;
    logic          t0_s_cyc, t0_s_stb, t0_s_we, t0_timeout;
    logic [1:0]    t0_gnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_2x1 #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
        .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt), .timeout(timeout)
    );

    wb_arbiter_2x1 #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk(clk), .rstn(rstn),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
        .m0_dat_r(t0_m0_dat_r), .m0_ack(t0_m0_ack), .m0_err(t0_m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_dat_r(t0_m1_dat_r), .m1_ack(t0_m1_ack), .m1_err(t0_m1_err),
        .s_adr(t0_s_adr), .s_dat_w(t0_s_dat_w), .s_sel(t0_s_sel),
        .s_cyc(t0_s_cyc), .s_stb(t0_s_stb), .s_we(t0_s_we),
        .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(t0_gnt), .timeout(t0_timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
    endtask

    // Pulse reset between edges.
    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
    endtask

    initial begin
        int unsigned bad;
        rstn = 1'b0;
        idle_inputs();
        #12;
        rstn = 1'b1;
        tick();
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_s_cyc", s_cyc, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        // Single master write, slave acks two cycles after strobe.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'hF000_1000;
        m0_dat_w = 32'h0000_00A5; m0_sel = 4'hF;
        #1;
        check("w_idle_gnt", gnt, 2'b00);
        check("w_idle_s_stb", s_stb, 1'b0);
        tick(); #1;
        check("w_gnt", gnt, 2'b01);
        check("w_s_adr", s_adr, 32'hF000_1000);
        check("w_s_dat_w", s_dat_w, 32'h0000_00A5);
        check("w_s_we", s_we, 1'b1);
        check("w_s_sel", s_sel, 4'hF);
        check("w_ack_early", m0_ack, 1'b0);
        tick(); #1;
        check("w_ack_wait", m0_ack, 1'b0);
        tick(); s_ack = 1; s_dat_r = 32'h1234_5678; #1;
        check("w_m0_ack", m0_ack, 1'b1);
        check("w_m1_ack", m1_ack, 1'b0);
        check("w_m0_dat_r", m0_dat_r, 32'h1234_5678);
        check("w_m1_dat_r", m1_dat_r, 32'h1234_5678);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0; #1;
        check("w_ack_pulse", m0_ack, 1'b0);
        check("w_gnt_hold", gnt, 2'b01);
        tick(); #1;
        check("w_gnt_rel", gnt, 2'b00);

        // Tie from reset, zero-bubble handover, alternating ties.
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        tick(); #1;
        check("tie1_gnt", gnt, 2'b01);
        check("tie1_adr", s_adr, 32'h100);
        tick(); s_ack = 1; #1;
        check("tie1_m0_ack", m0_ack, 1'b1);
        check("tie1_m1_ack", m1_ack, 1'b0);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
        check("ho_gnt_before", gnt, 2'b01);
        tick(); #1;
        check("ho_gnt", gnt, 2'b10);
        check("ho_adr", s_adr, 32'h200);
        tick(); s_ack = 1; #1;
        check("ho_m1_ack", m1_ack, 1'b1);
        check("ho_m0_ack", m0_ack, 1'b0);
        tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0; #1;
        tick(); m0_cyc = 1; m1_cyc = 1; #1;
        check("tie2_idle", gnt, 2'b00);
        tick(); #1;
        check("tie2_gnt", gnt, 2'b01);
        tick(); m0_cyc = 0; m1_cyc = 0;
        tick(); m0_cyc = 1; m1_cyc = 1;
        tick(); #1;
        check("tie3_gnt", gnt, 2'b10);
        tick(); m0_cyc = 0; m1_cyc = 0;
        tick(); #1;
        check("tie3_rel", gnt, 2'b00);

        // Grant hold: m1 does three beats while m0 waits.
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
        tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400; #1;
        check("hold_gnt0", gnt, 2'b10);
        for (int i = 0; i < 3; i++) begin
            s_ack = 1; s_err = (i == 0); #1;
            check("hold_gnt", gnt, 2'b10);
            check("hold_m1_ack", m1_ack, 1'b1);
            check("hold_m0_ack", m0_ack, 1'b0);
            if (i == 0) check("hold_ack_err_m1_err", m1_err, 1'b1);
            tick(); s_ack = 0; s_err = 0; #1;
            check("hold_gap_gnt", gnt, 2'b10);
            check("hold_gap_m0_ack", m0_ack, 1'b0);
            tick();
        end
        m1_cyc = 0; m1_stb = 0; #1;
        check("hold_rel_gnt", gnt, 2'b10);
        tick(); #1;
        check("hold_m0_gnt", gnt, 2'b01);
        check("hold_m0_adr", s_adr, 32'h400);
        m0_cyc = 0; m0_stb = 0;
        tick(); #1;
        check("hold_idle", gnt, 2'b00);

        // Watchdog abort of a stalled m0 read with m1 pending.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h500;
        tick(); m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wd_stall_gnt", gnt, 2'b01);
            check("wd_stall_err", m0_err, 1'b0);
            check("wd_stall_to", timeout, 1'b0);
            tick();
        end
        #1;
        check("wd_m0_err", m0_err, 1'b1);
        check("wd_m1_err", m1_err, 1'b0);
        check("wd_timeout", timeout, 1'b1);
        check("wd_s_cyc", s_cyc, 1'b0);
        check("wd_gnt", gnt, 2'b00);
        tick(); m0_cyc = 0; m0_stb = 0; #1;
        check("wd_to_pulse", timeout, 1'b0);
        check("wd_err_pulse", m0_err, 1'b0);
        check("wd_idle_gnt", gnt, 2'b00);
        tick(); #1;
        check("wd_m1_gnt", gnt, 2'b10);
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Ack in the 4th stalled cycle wins over the watchdog.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
        tick();
        tick();
        tick();
        tick(); s_ack = 1; #1;
        check("lim_m0_ack", m0_ack, 1'b1);
        check("lim_m0_err", m0_err, 1'b0);
        check("lim_timeout", timeout, 1'b0);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
        check("lim_gnt", gnt, 2'b01);
        check("lim_timeout2", timeout, 1'b0);
        check("lim_err2", m0_err, 1'b0);
        tick(); #1;
        check("lim_idle", gnt, 2'b00);

        // Watchdog disabled: 1000-cycle stall never aborts.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h800;
        tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (t0_timeout !== 1'b0 || t0_m0_err !== 1'b0 || t0_gnt !== 2'b01) bad++;
            tick();
        end
        check("nowd_no_abort", bad, 0);
        s_ack = 1; #1;
        check("nowd_m0_ack", t0_m0_ack, 1'b1);
        tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();

        // Async reset mid-transfer.
        do_reset();
        tick();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h900;
        tick(); #1;
        check("rmt_gnt", gnt, 2'b01);
        check("rmt_s_stb", s_stb, 1'b1);
        s_ack = 1;
        #1;
        rstn = 1'b0;
        #1;
        check("rmt_s_cyc", s_cyc, 1'b0);
        check("rmt_gnt0", gnt, 2'b00);
        check("rmt_m0_ack", m0_ack, 1'b0);
        s_ack = 0;
        m1_cyc = 1; m1_stb = 1;
        #1;
        rstn = 1'b1;
        tick(); #1;
        check("rmt_tie_gnt", gnt, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
